// File: rtl/bank_requester_pkg.sv
// Shared definitions for the shared-memory bank requester: default bank
// geometry, FSM state encoding and the round-robin pointer helper.
package bank_requester_pkg;

    localparam int BANK_ADDR_W_DEF = 8;
    localparam int BANK_DATA_W_DEF = 8;
    localparam int TIMEOUT_DEF     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } req_state_t;

    // Lane index following idx, wrapping at n (n need not be a power of two).
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requesting lane at or
// after ptr, wrapping. The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // Scan lanes in priority order starting at ptr; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (enable && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/bank_requester.sv
// Initiator side of one shared-memory bank: arbitrates the core lanes onto
// the bank port, runs one transaction at a time and returns the read data
// (or a timeout error) to the lane that was granted.
module bank_requester
    import bank_requester_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = BANK_ADDR_W_DEF,
    parameter int DATA_W  = BANK_DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      bank_read,
    output logic                      bank_write,
    output logic [ADDR_W-1:0]         bank_addr,
    output logic [DATA_W-1:0]         bank_wdata,
    input  logic [DATA_W-1:0]         bank_rdata,
    input  logic                      bank_finish
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);

    req_state_t         state_q,      state_d;
    logic [IDX_W-1:0]   ptr_q,        ptr_d;
    logic [IDX_W-1:0]   gnt_q,        gnt_d;
    logic               wr_q,         wr_d;
    logic [ADDR_W-1:0]  addr_q,       addr_d;
    logic [DATA_W-1:0]  wdata_q,      wdata_d;
    logic [TMR_W-1:0]   timer_q,      timer_d;
    logic               bank_read_q,  bank_read_d;
    logic               bank_write_q, bank_write_d;
    logic [NUM_REQ-1:0] rsp_valid_q,  rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q,  rsp_rdata_d;
    logic               rsp_err_q,    rsp_err_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_en;

    // Only offer a grant while idle and out of reset, so req_ready stays low
    // during reset even if lanes are already requesting.
    assign arb_en = (state_q == ST_IDLE) && reset;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (arb_en),
        .grant  (arb_grant),
        .idx    (arb_idx)
    );

    // Next-state and output decode; strobes and rsp_valid are one-cycle
    // pulses registered on the transition into ISSUE / RESP.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        timer_d      = timer_q;
        bank_read_d  = 1'b0;
        bank_write_d = 1'b0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_grant) begin
                    gnt_d        = arb_idx;
                    wr_d         = req_write[arb_idx];
                    addr_d       = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                    wdata_d      = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
                    bank_read_d  = ~req_write[arb_idx];
                    bank_write_d = req_write[arb_idx];
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Any finish seen here belongs to an earlier access.
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bank_finish) begin
                    rsp_rdata_d        = wr_q ? '0 : bank_rdata;
                    rsp_err_d          = 1'b0;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    rsp_rdata_d        = '0;
                    rsp_err_d          = 1'b1;
                    rsp_valid_d[gnt_q] = 1'b1;
                    state_d            = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                ptr_d   = IDX_W'(rr_next(int'(gnt_q), NUM_REQ));
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            timer_q      <= '0;
            bank_read_q  <= 1'b0;
            bank_write_q <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            timer_q      <= timer_d;
            bank_read_q  <= bank_read_d;
            bank_write_q <= bank_write_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = arb_grant;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign bank_read  = bank_read_q;
    assign bank_write = bank_write_q;
    assign bank_addr  = addr_q;
    assign bank_wdata = wdata_q;

endmodule

// File: tb/tb_bank_requester.sv
// Bench for bank_requester: directed scenarios followed by randomized
// traffic, checked against a lane/pointer/memory reference model.
module tb_bank_requester;

    localparam int N  = 4;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_write = '0;
    logic [N*8-1:0] req_addr = '0;
    logic [N*8-1:0] req_wdata = '0;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  rsp_valid;
    logic [7:0]    rsp_rdata;
    logic          rsp_err;
    logic          bank_read;
    logic          bank_write;
    logic [7:0]    bank_addr;
    logic [7:0]    bank_wdata;
    logic [7:0]    bank_rdata;
    logic          bank_finish;

    int checks = 0;
    int errors = 0;

    bank_requester #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .bank_read   (bank_read),
        .bank_write  (bank_write),
        .bank_addr   (bank_addr),
        .bank_wdata  (bank_wdata),
        .bank_rdata  (bank_rdata),
        .bank_finish (bank_finish)
    );

    always #5 clock = ~clock;

    // Bank model: registered, finish arrives fin_delay cycles after the
    // strobe (0 = never). A new strobe restarts the countdown.
    logic [7:0] mem [256];
    int         fin_delay = 1;
    int         cnt = 0;
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_data = '0;

    always @(posedge clock) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (bank_write) mem[bank_addr] <= bank_wdata;
        if (bank_read || bank_write) begin
            cnt        <= fin_delay;
            bank_rdata <= mem[bank_addr];
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end
    assign bank_finish = (cnt == 1);

    // Reference state
    logic [7:0] ref_mem [256];
    int         ref_ptr = 0;
    bit [N-1:0] pv = '0;
    bit         pw [N];
    logic [7:0] pa [N];
    logic [7:0] pd [N];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input bit v, input bit w,
                            input logic [7:0] a, input logic [7:0] d);
        req_valid[i]         = v;
        req_write[i]         = w;
        req_addr[i*8 +: 8]   = a;
        req_wdata[i*8 +: 8]  = d;
    endtask

    // Spec rule: first valid lane at or after the pointer, wrapping.
    function automatic int pick(input bit [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Called at an IDLE negedge with the request inputs already driven.
    // waitc = number of WAIT cycles before RESP.
    task automatic txn(input int lane, input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input int waitc, input logic [7:0] er, input bit ee, input bit consume);
        #1;
        chk("grant", 32'(req_ready), 32'(1) << lane);
        @(negedge clock);
        if (consume) set_lane(lane, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        #1;
        chk("issue_read",  32'(bank_read),  32'(!wr));
        chk("issue_write", 32'(bank_write), 32'(wr));
        chk("issue_addr",  32'(bank_addr),  32'(a));
        chk("issue_wdata", 32'(bank_wdata), 32'(d));
        chk("busy_ready",  32'(req_ready),  32'(0));
        for (int k = 0; k < waitc; k++) begin
            @(negedge clock);
            chk("wait_strobes", 32'({bank_read, bank_write}), 32'(0));
            chk("wait_addr",    32'(bank_addr), 32'(a));
            chk("wait_rsp",     32'(rsp_valid), 32'(0));
        end
        @(negedge clock);
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << lane);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(er));
        chk("rsp_err",   32'(rsp_err),   32'(ee));
        @(negedge clock);
        chk("rsp_pulse",      32'(rsp_valid), 32'(0));
        chk("rsp_rdata_hold", 32'(rsp_rdata), 32'(er));
        chk("rsp_err_hold",   32'(rsp_err),   32'(ee));
    endtask

    initial begin
        int  g, dly, waitc;
        bit  ee;
        logic [7:0] er;
        bit  seen;

        // Preload bank and reference memory while reset is held.
        req_valid = '1;
        for (int a = 0; a < 256; a++) begin
            @(negedge clock);
            pre_en   = 1'b1;
            pre_addr = 8'(a);
            pre_data = (a == 8'h3C) ? 8'hA5 : (a == 8'h22) ? 8'h5A : 8'($urandom);
            ref_mem[a] = pre_data;
        end
        @(negedge clock);
        pre_en = 1'b0;
        #1;
        chk("rst_ready",  32'(req_ready), 0);
        chk("rst_rsp",    32'({rsp_valid, rsp_rdata, rsp_err}), 0);
        chk("rst_strobe", 32'({bank_read, bank_write}), 0);
        chk("rst_bank",   32'({bank_addr, bank_wdata}), 0);
        req_valid = '0;
        @(negedge clock);
        reset = 1'b1;

        // Single read
        @(negedge clock);
        set_lane(0, 1'b1, 1'b0, 8'h3C, 8'h11);
        txn(0, 1'b0, 8'h3C, 8'h11, 1, 8'hA5, 1'b0, 1'b1);

        // Write then read on lane 2
        set_lane(2, 1'b1, 1'b1, 8'h10, 8'h7E);
        txn(2, 1'b1, 8'h10, 8'h7E, 1, 8'h00, 1'b0, 1'b1);
        ref_mem[8'h10] = 8'h7E;
        set_lane(2, 1'b1, 1'b0, 8'h10, 8'h33);
        txn(2, 1'b0, 8'h10, 8'h33, 1, 8'h7E, 1'b0, 1'b1);

        // Timeout, then a normal request
        fin_delay = 0;
        set_lane(1, 1'b1, 1'b0, 8'h55, 8'h00);
        txn(1, 1'b0, 8'h55, 8'h00, TO, 8'h00, 1'b1, 1'b1);
        fin_delay = 1;
        set_lane(3, 1'b1, 1'b0, 8'h56, 8'h00);
        txn(3, 1'b0, 8'h56, 8'h00, 1, ref_mem[8'h56], 1'b0, 1'b1);

        // Finish on the last WAIT cycle beats the timeout
        fin_delay = TO;
        set_lane(0, 1'b1, 1'b0, 8'h22, 8'h00);
        txn(0, 1'b0, 8'h22, 8'h00, TO, 8'h5A, 1'b0, 1'b1);
        fin_delay = 1;

        // Round-robin from reset with all lanes held valid
        reset = 1'b0;
        for (int i = 0; i < N; i++) set_lane(i, 1'b1, 1'b0, 8'(8'h40 + i), 8'(i));
        @(negedge clock);
        reset = 1'b1;
        for (int t = 0; t < 5; t++) begin
            g = t % N;
            txn(g, 1'b0, 8'(8'h40 + g), 8'(g), 1, ref_mem[8'h40 + g], 1'b0, 1'b0);
        end
        req_valid = '0;

        // Async reset in the middle of WAIT
        fin_delay = 0;
        @(negedge clock);
        set_lane(2, 1'b1, 1'b0, 8'h77, 8'h99);
        #1;
        chk("rst_mid_grant", 32'(req_ready), 32'h4);
        @(negedge clock);
        req_valid = '0;
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_strobe", 32'({bank_read, bank_write}), 0);
        chk("rst_mid_rsp",    32'(rsp_valid), 0);
        chk("rst_mid_addr",   32'(bank_addr), 0);
        chk("rst_mid_rdata",  32'(rsp_rdata), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (rsp_valid != '0) seen = 1'b1;
        end
        chk("rst_no_rsp", 32'(seen), 0);
        fin_delay = 1;
        set_lane(3, 1'b1, 1'b0, 8'h30, 8'h00);
        set_lane(0, 1'b1, 1'b0, 8'h31, 8'h00);
        txn(0, 1'b0, 8'h31, 8'h00, 1, ref_mem[8'h31], 1'b0, 1'b1);
        req_valid = '0;
        ref_ptr = 1;

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) begin
                    pv[i] = 1'b1;
                    pw[i] = 1'($urandom);
                    pa[i] = 8'($urandom_range(0, 15));
                    pd[i] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 7) == 0) pv[$urandom_range(0, N-1)] = 1'b0;
            if (pv == '0) begin
                g = $urandom_range(0, N-1);
                pv[g] = 1'b1;
                pw[g] = 1'($urandom);
                pa[g] = 8'($urandom_range(0, 15));
                pd[g] = 8'($urandom);
            end
            for (int i = 0; i < N; i++) set_lane(i, pv[i], pw[i], pa[i], pd[i]);
            g   = pick(pv, ref_ptr);
            dly = ($urandom_range(0, 9) < 7) ? 1 : int'($urandom_range(2, 19));
            fin_delay = dly;
            if (dly <= TO) begin
                waitc = dly;
                ee    = 1'b0;
                er    = pw[g] ? 8'h00 : ref_mem[pa[g]];
            end else begin
                waitc = TO;
                ee    = 1'b1;
                er    = 8'h00;
            end
            if (pw[g]) ref_mem[pa[g]] = pd[g];
            txn(g, pw[g], pa[g], pd[g], waitc, er, ee, 1'b1);
            pv[g]   = 1'b0;
            ref_ptr = (g + 1) % N;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
